// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int                 RETRY_W   = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;
    localparam logic [RETRY_W-1:0] RETRY_ONE = 4'd1;

    // Counter only ever holds (duration - 1), so clog2 of the largest duration is enough.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL reset, waits for a stable lock, then
// releases the downstream system reset and supervises lock while running.
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               status_clr,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               locked_ok,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lock_gated_s;
    logic             lock_s;

    // LOCK is meaningless while the PLL is held in reset, so it is masked
    // before synchronization; the lock search then starts from a clean 0.
    assign lock_gated_s = pll_lock & ~pll_reset;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lock_gated_s),
        .q     (lock_s)
    );

    // Sequencer FSM, shared down-counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= PLL_RST;
            cnt_r     <= RST_LOAD;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked_ok <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r   <= WAIT_LOCK;
                        cnt_r     <= TIMEOUT_LOAD;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r <= STABLE;
                        cnt_r   <= STABLE_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r   <= PLL_RST;
                        cnt_r     <= RST_LOAD;
                        pll_reset <= 1'b1;
                        if (retry_cnt != RETRY_MAX) begin
                            retry_cnt <= retry_cnt + RETRY_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= TIMEOUT_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r   <= RUN;
                        cnt_r     <= CNT_ZERO;
                        sys_rst_n <= 1'b1;
                        locked_ok <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RUN: begin
                    // Drop system reset on the very edge the loss is seen
                    if (!lock_s) begin
                        state_r   <= PLL_RST;
                        cnt_r     <= RST_LOAD;
                        pll_reset <= 1'b1;
                        sys_rst_n <= 1'b0;
                        locked_ok <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= PLL_RST;
                    cnt_r     <= RST_LOAD;
                    pll_reset <= 1'b1;
                    sys_rst_n <= 1'b0;
                    locked_ok <= 1'b0;
                end
            endcase
            // Clearing wins over a coincident set; the state move above still happens
            if (status_clr) begin
                lock_lost <= 1'b0;
                retry_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: hand-derived tables and sequences
// plus random lock patterns checked every cycle against a behavioural model.
module tb_pll_reset_seq;
    import pll_rst_pkg::*;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    typedef struct {
        int   cyc;
        logic exp_pll_reset;
        logic exp_sys_rst_n;
        logic exp_locked_ok;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       status_clr;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked_ok;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model: phase, cycles spent in it, sticky status, lock delay line
    int   m_phase;
    int   m_elapsed;
    int   m_retries;
    logic m_lost;
    logic m_s1;
    logic m_s2;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .status_clr (status_clr),
        .pll_reset  (pll_reset),
        .sys_rst_n  (sys_rst_n),
        .locked_ok  (locked_ok),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    function automatic logic [7:0] dut_vec();
        return {pll_reset, sys_rst_n, locked_ok, lock_lost, retry_cnt};
    endfunction

    function automatic logic [7:0] model_vec();
        logic run;
        run = (m_phase == PH_RUN);
        return {(m_phase == PH_RST), run, run, m_lost, 4'(m_retries)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_RST;
        m_elapsed = 0;
        m_retries = 0;
        m_lost    = 1'b0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    // One clock edge of the rules: durations counted upward from state entry
    task automatic model_step();
        logic seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_lock & (m_phase != PH_RST);
        case (m_phase)
            PH_RST: begin
                m_elapsed++;
                if (m_elapsed == RST_CYCLES) enter(PH_WAIT);
            end
            PH_WAIT: begin
                if (seen) begin
                    enter(PH_STABLE);
                end else begin
                    m_elapsed++;
                    if (m_elapsed == LOCK_TIMEOUT) begin
                        enter(PH_RST);
                        if (m_retries < 15) m_retries++;
                    end
                end
            end
            PH_STABLE: begin
                if (!seen) begin
                    enter(PH_WAIT);
                end else begin
                    m_elapsed++;
                    if (m_elapsed == STABLE_CYCLES) enter(PH_RUN);
                end
            end
            PH_RUN: begin
                if (!seen) begin
                    enter(PH_RST);
                    m_lost = 1'b1;
                end
            end
            default: enter(PH_RST);
        endcase
        if (status_clr) begin
            m_lost    = 1'b0;
            m_retries = 0;
        end
    endtask

    task automatic step(input logic lock, input logic clr);
        pll_lock   = lock;
        status_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("model", dut_vec(), model_vec());
    endtask

    // Assert rst_n between clock edges, check outputs at once, then restart
    task automatic do_reset(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        check(name, dut_vec(), 8'h80);
        repeat (2) @(negedge clk);
        status_clr = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        chk_t clean_tab[6];
        logic pr_hist[0:16];
        logic sr_hist[0:16];
        logic ok_hist[0:16];
        int   rst_high;
        int   first_rise;
        int   lat;
        int   waited;
        int   pulses;
        logic prev_pr;
        logic lv;
        int   len;

        clean_tab[0] = '{0,  1'b1, 1'b0, 1'b0};
        clean_tab[1] = '{3,  1'b1, 1'b0, 1'b0};
        clean_tab[2] = '{4,  1'b0, 1'b0, 1'b0};
        clean_tab[3] = '{14, 1'b0, 1'b0, 1'b0};
        clean_tab[4] = '{15, 1'b0, 1'b1, 1'b1};
        clean_tab[5] = '{16, 1'b0, 1'b1, 1'b1};

        // Clean start: lock high from reset release
        rst_n      = 1'b0;
        pll_lock   = 1'b1;
        status_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", dut_vec(), 8'h80);
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
        pr_hist[0] = pll_reset;
        sr_hist[0] = sys_rst_n;
        ok_hist[0] = locked_ok;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0);
            pr_hist[k] = pll_reset;
            sr_hist[k] = sys_rst_n;
            ok_hist[k] = locked_ok;
        end
        for (int i = 0; i < 6; i++) begin
            check("clean_start_table",
                  {pr_hist[clean_tab[i].cyc], sr_hist[clean_tab[i].cyc], ok_hist[clean_tab[i].cyc]},
                  {clean_tab[i].exp_pll_reset, clean_tab[i].exp_sys_rst_n, clean_tab[i].exp_locked_ok});
        end
        rst_high   = 0;
        first_rise = -1;
        for (int k = 0; k <= 16; k++) begin
            if (pr_hist[k]) rst_high++;
            if (sr_hist[k] && first_rise < 0) first_rise = k;
        end
        check("clean_pll_reset_cycles", rst_high, 4);
        check("clean_sys_rst_rise", first_rise, 15);

        // Lock loss in RUN for 3 cycles, full resequence, then status_clr
        repeat (3) step(1'b1, 1'b0);
        lat      = 0;
        rst_high = 0;
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0);
            if (!sys_rst_n && lat == 0) lat = k;
            if (pll_reset) rst_high++;
        end
        check("loss_latency", lat, 3);
        check("loss_lock_lost", lock_lost, 1);
        waited = 0;
        while (!sys_rst_n && waited < 60) begin
            step(1'b1, 1'b0);
            waited++;
            if (pll_reset) rst_high++;
        end
        check("reseq_run_reached", sys_rst_n, 1);
        check("reseq_pll_reset_cycles", rst_high, 4);
        check("reseq_lock_lost_sticky", lock_lost, 1);
        step(1'b1, 1'b1);
        check("status_clr_lost", lock_lost, 0);
        step(1'b1, 1'b0);
        do_reset("async_reset_in_run");

        // Timeout retry: 100 cycles without lock, then lock
        pulses  = 1;
        prev_pr = pll_reset;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 1'b0);
            if (pll_reset && !prev_pr) pulses++;
            prev_pr = pll_reset;
        end
        waited = 0;
        while (!sys_rst_n && waited < 40) begin
            step(1'b1, 1'b0);
            waited++;
            if (pll_reset && !prev_pr) pulses++;
            prev_pr = pll_reset;
        end
        check("retry_run_reached", sys_rst_n, 1);
        check("retry_count", retry_cnt, 2);
        check("retry_pll_reset_pulses", pulses, 3);

        // status_clr on the same edge as the lock-loss: flags clear, transition happens
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("clr_priority_lost", lock_lost, 0);
        check("clr_priority_retry", retry_cnt, 0);
        check("clr_priority_transition", {pll_reset, sys_rst_n}, 2'b10);
        step(1'b1, 1'b0);
        do_reset("reset_before_unstable");

        // Unstable lock: 5 high, 1 low, then high; RUN only after 8 clean cycles
        repeat (6) step(1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            step((i == 5) ? 1'b0 : 1'b1, 1'b0);
            check("unstable_sys_rst_n", sys_rst_n, (i >= 16) ? 1 : 0);
        end
        do_reset("reset_before_saturation");

        // Saturation: 20 timeouts, then async reset mid-WAIT_LOCK
        for (int k = 0; k < 20 * (RST_CYCLES + LOCK_TIMEOUT) + 10; k++) step(1'b0, 1'b0);
        check("retry_saturated", retry_cnt, 15);
        waited = 0;
        while (!(m_phase == PH_WAIT && m_elapsed >= 4) && waited < 50) begin
            step(1'b0, 1'b0);
            waited++;
        end
        check("sat_in_wait_lock", {pll_reset, sys_rst_n}, 2'b00);
        do_reset("async_reset_in_wait");

        // Random lock bursts with occasional status_clr pulses
        for (int r = 0; r < 40; r++) begin
            lv  = 1'($urandom_range(0, 1));
            len = (r % 4 == 3) ? 1 : $urandom_range(1, 40);
            for (int j = 0; j < len; j++) begin
                step(lv, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            end
        end
        status_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high per attempt (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles to wait for lock before retry (about 2.4 ms at 27 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: cycles lock must stay continuously high before system reset release.
REQ-004 SHALL have port clk, input, 1: free-running 27 MHz board reference clock, the same clock that feeds the PLL CLKIN.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pll_lock, input, 1: raw PLL LOCK, asynchronous to clk.
REQ-007 SHALL have port status_clr, input, 1: synchronous pulse that clears lock_lost and retry_cnt.
REQ-008 SHALL have port pll_reset, output, 1: drives PLL RESET, active-high.
REQ-009 SHALL have port sys_rst_n, output, 1: active-low system reset for downstream logic.
REQ-010 SHALL have port locked_ok, output, 1: high only in state RUN.
REQ-011 SHALL have port lock_lost, output, 1: sticky flag, set when lock drops while in RUN.
REQ-012 SHALL have port retry_cnt, output, 4: saturating count of lock timeouts.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer; all logic uses only the synchronized value lock_s.
REQ-014 SHALL implement four FSM states:
- PLL_RST: pll_reset=1; counter runs RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: when lock_s=1, go to STABLE. When the counter reaches LOCK_TIMEOUT-1, go to PLL_RST and increment retry_cnt.
- STABLE: lock_s=0 returns to WAIT_LOCK with the counter restarted. STABLE_CYCLES consecutive high cycles go to RUN.
- RUN: lock_s=0 goes to PLL_RST and sets lock_lost.
REQ-015 SHALL hold sys_rst_n=0 in all states except RUN; sys_rst_n is registered and rises in the first RUN cycle.
REQ-016 SHALL assert sys_rst_n=0 in the same cycle lock_s is sampled low in RUN, registered with no extra delay.
REQ-017 SHALL use a single shared down-counter, reloaded on every state entry, sized by $clog2 of the largest parameter.
REQ-018 SHALL saturate retry_cnt at 15; lock_lost stays set until status_clr or reset.
REQ-019 SHALL give status_clr priority when it coincides with a set event in the same cycle: the flag/count ends cleared, but the state transition still occurs.
REQ-020 SHALL produce minimum latency of 3+RST_CYCLES+STABLE_CYCLES cycles from reset release to sys_rst_n=1 when lock is immediate (2 synchronizer cycles plus 1 transition cycle).
REQ-021 SHALL treat a lock glitch shorter than 1 cycle as possibly unseen; no filtering beyond the synchronizer and STABLE is required.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously force:
- state to PLL_RST with counter loaded;
- pll_reset=1, sys_rst_n=0, locked_ok=0, lock_lost=0, retry_cnt=0;
- synchronizer flops to 0.
REQ-023 SHALL, when rst_n is asserted mid-operation (including RUN), drop sys_rst_n immediately and restart the sequence from PLL_RST.

Structure
REQ-024 SHALL place in shared package pll_rst_pkg: the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN) and the retry counter width constant (4).
REQ-025 SHALL instantiate the synchronizer as sub-module sync_2ff (1-bit, async active-low reset, reset value 0).
REQ-026 SHALL keep the FSM and counter in pll_reset_seq; no clock generation or primitive instantiation in this block.

Verification
REQ-027 SHALL use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8 for all scenarios.
REQ-028 Scenario (clean start): pll_lock tied 1 from reset release -> pll_reset high exactly 4 cycles; sys_rst_n rises 15 cycles after release; locked_ok=1.
REQ-029 Scenario (timeout retry): pll_lock held 0 for 100 cycles, then 1 -> retry_cnt=2 (two 32-cycle timeouts); sys_rst_n then rises after 8 stable cycles; pll_reset pulsed 3 times in total.
REQ-030 Scenario (unstable lock): lock high 5 cycles, low 1, then high -> no RUN entry until 8 consecutive high cycles; sys_rst_n stays 0 throughout.
REQ-031 Scenario (lock loss): lock dropped for 3 cycles while in RUN -> sys_rst_n=0 within 3 cycles of the drop; lock_lost=1; full resequence; status_clr pulse clears lock_lost to 0.
REQ-032 Scenario (saturation and reset): lock held 0 for 20 timeouts -> retry_cnt=15; then rst_n pulsed low mid-WAIT_LOCK -> all outputs return to reset values asynchronously, same cycle.
